// File: rtl/sgmii_link_ctrl.sv
// sgmii_link_ctrl
//   Link-state controller for the SGMII PCS/PMA path. Registers the core's
//   status vector, sequences auto-negotiation restarts, debounces link-up,
//   latches the negotiated speed into the core speed selects, holds the MAC
//   in reset while the link is down and pulses an interrupt on every link
//   state change.
//
// Ports
//   clock              in   125 MHz userclk2
//   reset              in   asynchronous, active-high
//   status_vector[15:0] in  PCS status: [0] link, [1] sync, [11:10] speed,
//                           [12] duplex, [13] remote fault
//   an_interrupt       in   AN-complete pulse from the core
//   an_restart_config  out  AN restart request to the core
//   speed_is_10_100    out  core speed select
//   speed_is_100       out  core speed select
//   mac_reset          out  active-high reset to MAC and FIFOs
//   link_up            out  link qualified
//   link_speed[1:0]    out  latched speed code (00=10, 01=100, 10=1000)
//   link_irq           out  one-cycle pulse on each link_up change
//
// Optional feature (macro SGMII_LINK_FLAP_COUNT_EN)
//   flap_clear         in   synchronous clear of flap_count (wins over increment)
//   flap_count[15:0]   out  saturating count of UP -> AN_WAIT transitions

module sgmii_link_ctrl #(
  parameter int LINK_DEBOUNCE  = 1250,
  parameter int AN_TIMEOUT     = 1250000,
  parameter int RESTART_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] status_vector,
  input  logic        an_interrupt,
  output logic        an_restart_config,
  output logic        speed_is_10_100,
  output logic        speed_is_100,
  output logic        mac_reset,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        link_irq
`ifdef SGMII_LINK_FLAP_COUNT_EN
  ,
  input  logic        flap_clear,
  output logic [15:0] flap_count
`endif
);

  localparam int DB_W = $clog2(LINK_DEBOUNCE + 1);
  localparam int TO_W = $clog2(AN_TIMEOUT + 1);

  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(LINK_DEBOUNCE);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(AN_TIMEOUT - 1);
  localparam logic [7:0]      RS_LAST = 8'(RESTART_CYCLES);

  typedef enum logic [1:0] {
    S_RESTART = 2'd0,
    S_AN_WAIT = 2'd1,
    S_UP      = 2'd2
  } state_t;

  logic [15:0]     r_sv_q;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [DB_W-1:0] r_db_cnt;
  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_rs_cnt;

  logic            r_restart;
  logic            r_mac_reset;
  logic            r_link_up;
  logic [1:0]      r_link_speed;
  logic            r_spd_10_100;
  logic            r_spd_100;
  logic            r_link_irq;

  logic            w_link_ok;
  logic            w_db_done;
  logic            w_to_done;
  logic            w_enter_up;
  logic            w_leave_up;
  logic [1:0]      w_code;
  logic            w_restart_nxt;
  logic            w_up_nxt;
  logic            w_irq_nxt;
  logic [1:0]      w_speed_nxt;
  logic            w_spd_10_100_nxt;
  logic            w_spd_100_nxt;

  // Status bits that no decision depends on.
  logic            w_unused_sv;
  assign w_unused_sv = ^{r_sv_q[15:14], r_sv_q[12], r_sv_q[9:2]};

  // ---- input register stage ----
  always_ff @(posedge clock) begin
    r_sv_q <= status_vector;
  end

  assign w_link_ok = r_sv_q[0] & r_sv_q[1] & ~r_sv_q[13];
  // Debounce qualifies on the registered count, which gives the
  // input-register + output-register latency on link-up.
  assign w_db_done = (r_db_cnt >= DB_MAX);
  // Timeout fires when this cycle's increment would reach AN_TIMEOUT;
  // an AN-complete pulse in the same cycle restarts the wait instead.
  assign w_to_done = ~an_interrupt && (r_to_cnt >= TO_LAST);

  // ---- FSM: next-state ----
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESTART: begin
        if (r_rs_cnt >= RS_LAST) w_state_nxt = S_AN_WAIT;
      end
      S_AN_WAIT: begin
        if (w_db_done)      w_state_nxt = S_UP;
        else if (w_to_done) w_state_nxt = S_RESTART;
      end
      S_UP: begin
        if (!w_link_ok || (r_sv_q[11:10] != r_link_speed)) w_state_nxt = S_AN_WAIT;
      end
      default: w_state_nxt = S_RESTART;
    endcase
  end

  // ---- FSM: state and counters ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_RESTART;
      r_db_cnt <= '0;
      r_to_cnt <= '0;
      r_rs_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;

      // The entry edge into RESTART already drives the first pulse cycle,
      // so a re-entry starts counting at 1. Out of reset the output
      // register is still low, so counting starts at 0 there.
      if (r_state != S_RESTART)
        r_rs_cnt <= (w_state_nxt == S_RESTART) ? 8'd1 : 8'd0;
      else if (r_rs_cnt != 8'hFF)
        r_rs_cnt <= r_rs_cnt + 8'd1;

      if ((r_state == S_AN_WAIT) && (w_state_nxt == S_AN_WAIT)) begin
        if (!w_link_ok)           r_db_cnt <= '0;
        else if (r_db_cnt != DB_MAX) r_db_cnt <= r_db_cnt + 1'b1;

        if (an_interrupt)         r_to_cnt <= '0;
        else if (r_to_cnt != {TO_W{1'b1}}) r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_db_cnt <= '0;
        r_to_cnt <= '0;
      end
    end
  end

  // ---- FSM: outputs (computed from next state, then registered) ----
  assign w_enter_up = (w_state_nxt == S_UP) && (r_state != S_UP);
  assign w_leave_up = (w_state_nxt == S_AN_WAIT) && (r_state == S_UP);
  // Reserved speed code 11 is treated as 1000.
  assign w_code = (r_sv_q[11:10] == 2'b11) ? 2'b10 : r_sv_q[11:10];

  always_comb begin
    w_restart_nxt    = (w_state_nxt == S_RESTART);
    w_up_nxt         = (w_state_nxt == S_UP);
    w_irq_nxt        = (w_up_nxt != r_link_up);
    w_speed_nxt      = r_link_speed;
    w_spd_10_100_nxt = r_spd_10_100;
    w_spd_100_nxt    = r_spd_100;
    if (w_enter_up) begin
      w_speed_nxt      = w_code;
      w_spd_10_100_nxt = (w_code != 2'b10);
      w_spd_100_nxt    = (w_code == 2'b01);
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_restart    <= 1'b0;
      r_mac_reset  <= 1'b1;
      r_link_up    <= 1'b0;
      r_link_speed <= 2'b10;
      r_spd_10_100 <= 1'b0;
      r_spd_100    <= 1'b0;
      r_link_irq   <= 1'b0;
    end else begin
      r_restart    <= w_restart_nxt;
      r_mac_reset  <= ~w_up_nxt;
      r_link_up    <= w_up_nxt;
      r_link_speed <= w_speed_nxt;
      r_spd_10_100 <= w_spd_10_100_nxt;
      r_spd_100    <= w_spd_100_nxt;
      r_link_irq   <= w_irq_nxt;
    end
  end

  assign an_restart_config = r_restart;
  assign mac_reset         = r_mac_reset;
  assign link_up           = r_link_up;
  assign link_speed        = r_link_speed;
  assign speed_is_10_100   = r_spd_10_100;
  assign speed_is_100      = r_spd_100;
  assign link_irq          = r_link_irq;

`ifdef SGMII_LINK_FLAP_COUNT_EN
  logic [15:0] r_flap_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_flap_cnt <= 16'h0000;
    end else if (flap_clear) begin
      r_flap_cnt <= 16'h0000;
    end else if (w_leave_up && (r_flap_cnt != 16'hFFFF)) begin
      r_flap_cnt <= r_flap_cnt + 16'h0001;
    end
  end

  assign flap_count = r_flap_cnt;
`else
  logic w_unused_leave;
  assign w_unused_leave = w_leave_up;
`endif

endmodule

// File: tb/tb_sgmii_link_ctrl.sv
module tb_sgmii_link_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] status_vector;
  logic        an_interrupt;
  logic        an_restart_config;
  logic        speed_is_10_100;
  logic        speed_is_100;
  logic        mac_reset;
  logic        link_up;
  logic [1:0]  link_speed;
  logic        link_irq;
`ifdef SGMII_LINK_FLAP_COUNT_EN
  logic        flap_clear;
  logic [15:0] flap_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  sgmii_link_ctrl #(
    .LINK_DEBOUNCE (4),
    .AN_TIMEOUT    (100),
    .RESTART_CYCLES(16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .status_vector    (status_vector),
    .an_interrupt     (an_interrupt),
    .an_restart_config(an_restart_config),
    .speed_is_10_100  (speed_is_10_100),
    .speed_is_100     (speed_is_100),
    .mac_reset        (mac_reset),
    .link_up          (link_up),
    .link_speed       (link_speed),
    .link_irq         (link_irq)
`ifdef SGMII_LINK_FLAP_COUNT_EN
    ,
    .flap_clear       (flap_clear),
    .flap_count       (flap_count)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] sv;
    logic        up;
    logic        irq;
    logic [1:0]  spd;
    logic        s10100;
    logic        s100;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [15:0] sv, input logic up, input logic irq,
                     input logic [1:0] spd, input logic a, input logic b);
    vec_t v;
    v.sv = sv; v.up = up; v.irq = irq; v.spd = spd; v.s10100 = a; v.s100 = b;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, " link_up"},         {31'd0, link_up},         {31'd0, v.up});
    chk({tag, " mac_reset"},       {31'd0, mac_reset},       {31'd0, ~v.up});
    chk({tag, " link_irq"},        {31'd0, link_irq},        {31'd0, v.irq});
    chk({tag, " link_speed"},      {30'd0, link_speed},      {30'd0, v.spd});
    chk({tag, " speed_is_10_100"}, {31'd0, speed_is_10_100}, {31'd0, v.s10100});
    chk({tag, " speed_is_100"},    {31'd0, speed_is_100},    {31'd0, v.s100});
  endtask

  initial begin
    vec_t rv;
    bit   exp_rs;

    // Link sequence table, applied right after the restart/timeout phase.
    for (int t = 0; t <= 4; t++)  add(16'h0403, 0, 0, 2'b10, 0, 0);
    add(16'h0403, 1, 1, 2'b01, 1, 1);                       // t5 up at 100
    add(16'h0403, 1, 0, 2'b01, 1, 1);
    add(16'h0402, 1, 0, 2'b01, 1, 1);                       // t7 link drops
    add(16'h0402, 0, 1, 2'b01, 1, 1);                       // t8 down two cycles later
    add(16'h0402, 0, 0, 2'b01, 1, 1);
    for (int t = 10; t <= 14; t++) add(16'h0803, 0, 0, 2'b01, 1, 1);
    add(16'h0803, 1, 1, 2'b10, 0, 0);                       // t15 up at 1000
    add(16'h0803, 1, 0, 2'b10, 0, 0);
    add(16'h0003, 1, 0, 2'b10, 0, 0);                       // t17 speed -> 10
    add(16'h0003, 0, 1, 2'b10, 0, 0);                       // t18 down
    for (int t = 19; t <= 22; t++) add(16'h0003, 0, 0, 2'b10, 0, 0);
    add(16'h0003, 1, 1, 2'b00, 1, 0);                       // t23 up at 10
    add(16'h0003, 1, 0, 2'b00, 1, 0);
    add(16'h2003, 1, 0, 2'b00, 1, 0);                       // t25 remote fault
    add(16'h0000, 0, 1, 2'b00, 1, 0);
    add(16'h0000, 0, 0, 2'b00, 1, 0);
    for (int t = 28; t <= 39; t++)                          // glitch every 3rd cycle
      add(((t - 28) % 3 == 2) ? 16'h0402 : 16'h0403, 0, 0, 2'b00, 1, 0);
    for (int t = 40; t <= 44; t++) add(16'h0403, 0, 0, 2'b00, 1, 0);
    add(16'h0403, 1, 1, 2'b01, 1, 1);                       // t45
    add(16'h0403, 1, 0, 2'b01, 1, 1);
    add(16'h0C03, 1, 0, 2'b01, 1, 1);                       // t47 reserved code 11
    add(16'h0C03, 0, 1, 2'b01, 1, 1);
    for (int t = 49; t <= 52; t++) add(16'h0C03, 0, 0, 2'b01, 1, 1);
    add(16'h0C03, 1, 1, 2'b10, 0, 0);                       // t53 11 latched as 10
    add(16'h0000, 0, 1, 2'b10, 0, 0);                       // 11 != 10 -> drop
    add(16'h0000, 0, 0, 2'b10, 0, 0);

    // Reset state.
    reset = 1'b1;
    status_vector = 16'h0000;
    an_interrupt = 1'b0;
`ifdef SGMII_LINK_FLAP_COUNT_EN
    flap_clear = 1'b0;
`endif
    repeat (3) step();
    chk("rst an_restart_config", {31'd0, an_restart_config}, 32'd0);
    rv.sv = 16'h0; rv.up = 0; rv.irq = 0; rv.spd = 2'b10; rv.s10100 = 0; rv.s100 = 0;
    chk_outs("rst", rv);
    reset = 1'b0;

    // Restart pulse, AN timeout, and timeout delayed by an_interrupt.
    for (int i = 1; i <= 300; i++) begin
      an_interrupt = (i == 183);
      status_vector = 16'h0000;
      step();
      exp_rs = (i <= 16) || (i >= 117 && i <= 132) || (i >= 283 && i <= 298);
      chk($sformatf("restart c%0d an_restart_config", i), {31'd0, an_restart_config}, {31'd0, exp_rs});
      chk($sformatf("restart c%0d mac_reset", i), {31'd0, mac_reset}, 32'd1);
      chk($sformatf("restart c%0d link_irq", i), {31'd0, link_irq}, 32'd0);
    end
    an_interrupt = 1'b0;

    // Table-driven link sequence.
    foreach (tbl[t]) begin
      status_vector = tbl[t].sv;
      step();
      chk_outs($sformatf("vec%0d", t), tbl[t]);
      chk($sformatf("vec%0d an_restart_config", t), {31'd0, an_restart_config}, 32'd0);
    end

    // Asynchronous reset while link is up.
    status_vector = 16'h0403;
    repeat (8) step();
    chk("pre-async link_up", {31'd0, link_up}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    rv.sv = 16'h0; rv.up = 0; rv.irq = 0; rv.spd = 2'b10; rv.s10100 = 0; rv.s100 = 0;
    chk_outs("async rst", rv);
    status_vector = 16'h0000;
    step();
    reset = 1'b0;

    // Reset truncates an in-progress restart pulse.
    repeat (5) step();
    chk("restart before trunc", {31'd0, an_restart_config}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("restart truncated", {31'd0, an_restart_config}, 32'd0);
    step();
    reset = 1'b0;

`ifdef SGMII_LINK_FLAP_COUNT_EN
    chk("flap reset", {16'd0, flap_count}, 32'd0);
    repeat (17) step();
    for (int k = 0; k < 3; k++) begin
      status_vector = 16'h0403;
      repeat (7) step();
      chk($sformatf("flap up%0d", k), {31'd0, link_up}, 32'd1);
      status_vector = 16'h0402;
      repeat (3) step();
      chk($sformatf("flap down%0d", k), {31'd0, link_up}, 32'd0);
    end
    chk("flap count 3", {16'd0, flap_count}, 32'd3);
    status_vector = 16'h0403;
    repeat (7) step();
    status_vector = 16'h0402;
    step();
    flap_clear = 1'b1;
    step();
    flap_clear = 1'b0;
    chk("flap drop4 link_up", {31'd0, link_up}, 32'd0);
    chk("flap clear wins", {16'd0, flap_count}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
